// File: rtl/sdram_word_bridge.sv
// rtl/sdram_word_bridge.sv - 32-bit CPU word access split into two 16-bit SDRAM controller transfers
module sdram_word_bridge (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_busy,
  output logic [21:0] avl_addr,
  output logic [1:0]  avl_byte_en,
  output logic        avl_WRITEen,
  output logic        avl_READen,
  output logic [15:0] avl_WRDATA,
  input  logic [15:0] avl_RDDATA,
  input  logic        avl_req_wait
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nx;
  logic        we_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [15:0] rd_lo;

  logic        accept, lo_cpl, hi_cpl;
  logic        src_we;
  logic [20:0] src_addr;
  logic [31:0] src_wdata;
  logic [3:0]  src_be;
  logic [21:0] addr_nx;
  logic [1:0]  byte_en_nx;
  logic [15:0] wrdata_nx;
  logic        wr_nx, rd_nx;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    accept    = (state == IDLE) && cpu_req;
    lo_cpl    = (state == LO) && !avl_req_wait;
    hi_cpl    = (state == HI) && !avl_req_wait;
    // The accepting cycle drives the bus from the live request, later cycles from the latch
    src_we    = accept ? cpu_we    : we_q;
    src_addr  = accept ? cpu_addr  : addr_q;
    src_wdata = accept ? cpu_wdata : wdata_q;
    src_be    = accept ? cpu_be    : be_q;

    state_nx = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we && cpu_be == 4'b0000)     state_nx = DONE;
          else if (cpu_we && cpu_be[1:0] == 2'b00) state_nx = HI;
          else                                 state_nx = LO;
        end
      end
      LO:      if (!avl_req_wait) state_nx = (we_q && be_q[3:2] == 2'b00) ? DONE : HI;
      HI:      if (!avl_req_wait) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    addr_nx    = '0;
    byte_en_nx = '0;
    wrdata_nx  = '0;
    wr_nx      = 1'b0;
    rd_nx      = 1'b0;
    if (state_nx == LO) begin
      addr_nx    = {src_addr, 1'b0};
      byte_en_nx = src_we ? src_be[1:0] : 2'b11;
      wrdata_nx  = src_wdata[15:0];
      wr_nx      = src_we;
      rd_nx      = !src_we;
    end else if (state_nx == HI) begin
      addr_nx    = {src_addr, 1'b1};
      byte_en_nx = src_we ? src_be[3:2] : 2'b11;
      wrdata_nx  = src_wdata[31:16];
      wr_nx      = src_we;
      rd_nx      = !src_we;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_lo       <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_busy    <= 1'b0;
      avl_addr    <= '0;
      avl_byte_en <= '0;
      avl_WRDATA  <= '0;
      avl_WRITEen <= 1'b0;
      avl_READen  <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        be_q    <= cpu_be;
      end
      avl_addr    <= addr_nx;
      avl_byte_en <= byte_en_nx;
      avl_WRDATA  <= wrdata_nx;
      avl_WRITEen <= wr_nx;
      avl_READen  <= rd_nx;
      cpu_ready   <= (state_nx == DONE);
      cpu_busy    <= (state_nx != IDLE);
      // Low half is staged so cpu_rdata only changes once the whole word is in
      if (lo_cpl && !we_q) rd_lo <= avl_RDDATA;
      if (hi_cpl && !we_q) cpu_rdata <= {avl_RDDATA, rd_lo};
    end
  end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb/tb_sdram_word_bridge.sv - self-checking bench for sdram_word_bridge
module tb_sdram_word_bridge;

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } xfer_t;

  typedef struct {
    logic        we;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    int          exp_xfers;
    logic [21:0] exp_addr0;
    logic [1:0]  exp_be0;
    logic [15:0] exp_data0;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        sys_clk, rst;
  logic        cpu_req, cpu_we;
  logic [20:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_busy;
  logic [21:0] avl_addr;
  logic [1:0]  avl_byte_en;
  logic        avl_WRITEen, avl_READen;
  logic [15:0] avl_WRDATA, avl_RDDATA;
  logic        avl_req_wait;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  logic glitch_req = 1'b0;
  int ready_cnt = 0;
  int last_cpl_edge = 0;
  int both_err = 0, dup_err = 0, unstable_err = 0;
  xfer_t xlog[$];
  logic [15:0] smem [logic [21:0]];
  logic [31:0] rmem [logic [20:0]];

  sdram_word_bridge dut (
    .sys_clk(sys_clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .avl_addr(avl_addr), .avl_byte_en(avl_byte_en), .avl_WRITEen(avl_WRITEen),
    .avl_READen(avl_READen), .avl_WRDATA(avl_WRDATA), .avl_RDDATA(avl_RDDATA),
    .avl_req_wait(avl_req_wait)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial forever begin
    @(negedge sys_clk);
    if (cpu_ready === 1'b1) ready_cnt++;
  end

  // Background memory contents; 0x20/0x21 hold the fixed pattern for the directed read
  function automatic logic [15:0] hw_init(input logic [21:0] a);
    if (a == 22'h000020) return 16'h1234;
    if (a == 22'h000021) return 16'hABCD;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] slave_rd(input logic [21:0] a);
    if (smem.exists(a)) return smem[a];
    return hw_init(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [20:0] a);
    if (rmem.exists(a)) return rmem[a];
    return {hw_init({a, 1'b1}), hw_init({a, 1'b0})};
  endfunction

  // Controller model: completes each request lat cycles after en, one wait=0 cycle per transfer
  initial begin
    int cnt;
    xfer_t hold;
    logic [21:0] last_addr;
    logic [15:0] v;
    cnt = 0;
    hold = '0;
    last_addr = '0;
    avl_req_wait = 1'b1;
    avl_RDDATA = '0;
    forever begin
      @(negedge sys_clk);
      if (avl_WRITEen && avl_READen) both_err++;
      if (rst) begin
        avl_req_wait = 1'b1;
        cnt = 0;
      end else if (!avl_req_wait) begin
        avl_req_wait = 1'b1;
        cnt = 0;
        if ((avl_WRITEen || avl_READen) && avl_addr == last_addr) dup_err++;
      end else if (glitch_req) begin
        avl_req_wait = 1'b0;
      end else if (avl_WRITEen || avl_READen) begin
        if (cnt == 0) hold = {avl_WRITEen, avl_addr, avl_WRDATA, avl_byte_en};
        else if (hold != {avl_WRITEen, avl_addr, avl_WRDATA, avl_byte_en}) unstable_err++;
        cnt++;
        if (cnt >= lat) begin
          avl_req_wait = 1'b0;
          last_addr = avl_addr;
          last_cpl_edge = cyc + 1;
          if (avl_WRITEen) begin
            v = slave_rd(avl_addr);
            if (avl_byte_en[0]) v[7:0]  = avl_WRDATA[7:0];
            if (avl_byte_en[1]) v[15:8] = avl_WRDATA[15:8];
            smem[avl_addr] = v;
            xlog.push_back({1'b1, avl_addr, avl_WRDATA, avl_byte_en});
          end else begin
            avl_RDDATA = slave_rd(avl_addr);
            xlog.push_back({1'b0, avl_addr, avl_RDDATA, avl_byte_en});
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge sys_clk);
    while (cpu_busy && g < 100) begin
      @(negedge sys_clk);
      g++;
    end
    chk("idle_wait", cpu_busy, 0);
  endtask

  task automatic run_txn(input logic we, input logic [20:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int l,
                         output int nx, output xfer_t first, output logic [31:0] rd);
    xfer_t exp_q[$];
    logic [31:0] exp_rd, rd_before, w;
    int start, g;
    exp_rd = ref_rd(addr);
    if (!we) begin
      exp_q.push_back({1'b0, addr, 1'b0, 16'h0, 2'b11});
      exp_q.push_back({1'b0, addr, 1'b1, 16'h0, 2'b11});
    end else begin
      if (be[1:0] != 0) exp_q.push_back({1'b1, addr, 1'b0, wdata[15:0], be[1:0]});
      if (be[3:2] != 0) exp_q.push_back({1'b1, addr, 1'b1, wdata[31:16], be[3:2]});
      w = exp_rd;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
      rmem[addr] = w;
    end
    lat = l;
    wait_idle();
    start = xlog.size();
    rd_before = cpu_rdata;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be; cpu_req = 1'b1;
    @(posedge sys_clk);
    #1 cpu_req = 1'b0;
    @(negedge sys_clk);
    if (exp_q.size() == 0) chk("ready_after_accept", cpu_ready, 1);
    else chk("en_after_accept", we ? avl_WRITEen : avl_READen, 1);
    g = 0;
    while (!cpu_ready && g < 200) begin
      @(negedge sys_clk);
      g++;
    end
    chk("ready_seen", cpu_ready, 1);
    if (exp_q.size() > 0) chk("ready_latency", 64'(cyc), 64'(last_cpl_edge));
    rd = cpu_rdata;
    if (!we) chk("rdata", cpu_rdata, exp_rd);
    else chk("rdata_hold", cpu_rdata, rd_before);
    @(negedge sys_clk);
    chk("ready_one_cycle", cpu_ready, 0);
    nx = xlog.size() - start;
    chk("xfer_count", 64'(nx), 64'(exp_q.size()));
    for (int i = 0; i < nx && i < exp_q.size(); i++) begin
      chk("xfer_we", xlog[start+i].we, exp_q[i].we);
      chk("xfer_addr", xlog[start+i].addr, exp_q[i].addr);
      chk("xfer_be", xlog[start+i].be, exp_q[i].be);
      if (we) chk("xfer_wdata", xlog[start+i].data, exp_q[i].data);
    end
    first = (nx > 0) ? xlog[start] : '0;
  endtask

  initial begin
    vec_t vecs[8];
    int r_nx, r0, s0, pulses, g;
    xfer_t r_first;
    logic [31:0] r_rd;

    vecs[0] = '{1'b0, 21'h000010, 32'h0,        4'hF, 6, 2, 22'h000020, 2'b11, 16'h1234, 32'hABCD1234};
    vecs[1] = '{1'b1, 21'h1FFFFF, 32'hDEADBEEF, 4'hF, 2, 2, 22'h3FFFFE, 2'b11, 16'hBEEF, 32'h0};
    vecs[2] = '{1'b1, 21'h000040, 32'h12345678, 4'hC, 1, 1, 22'h000081, 2'b11, 16'h1234, 32'h0};
    vecs[3] = '{1'b1, 21'h000041, 32'hCAFEF00D, 4'h2, 3, 1, 22'h000082, 2'b10, 16'hF00D, 32'h0};
    vecs[4] = '{1'b1, 21'h000050, 32'h55555555, 4'h0, 1, 0, 22'h0,      2'b00, 16'h0,    32'h0};
    vecs[5] = '{1'b0, 21'h000040, 32'h0,        4'h0, 1, 2, 22'h000080, 2'b11, 16'h5ADA, 32'h12345ADA};
    vecs[6] = '{1'b0, 21'h000041, 32'h0,        4'h0, 4, 2, 22'h000082, 2'b11, 16'hF0D8, 32'h5AD9F0D8};
    vecs[7] = '{1'b0, 21'h1FFFFF, 32'h0,        4'h0, 2, 2, 22'h3FFFFE, 2'b11, 16'hBEEF, 32'hDEADBEEF};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_en", {avl_WRITEen, avl_READen}, 0);
    chk("rst_addr", avl_addr, 0);
    chk("rst_be_wrdata", {avl_byte_en, avl_WRDATA}, 0);
    #2 rst = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].lat, r_nx, r_first, r_rd);
      chk("vec_xfers", 64'(r_nx), 64'(vecs[i].exp_xfers));
      if (vecs[i].exp_xfers > 0) begin
        chk("vec_addr0", r_first.addr, vecs[i].exp_addr0);
        chk("vec_be0", r_first.be, vecs[i].exp_be0);
        chk("vec_data0", r_first.data, vecs[i].exp_data0);
      end
      if (!vecs[i].we) chk("vec_rdata", r_rd, vecs[i].exp_rdata);
    end

    // wait strobe while idle must not move the FSM
    wait_idle();
    r0 = ready_cnt; s0 = xlog.size();
    @(posedge sys_clk); glitch_req = 1'b1;
    @(posedge sys_clk); glitch_req = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("glitch_busy", cpu_busy, 0);
    chk("glitch_ready", 64'(ready_cnt - r0), 0);
    chk("glitch_xfers", 64'(xlog.size() - s0), 0);

    // request held high for three back-to-back reads
    lat = 2;
    wait_idle();
    s0 = xlog.size(); r0 = ready_cnt; pulses = 0; g = 0;
    cpu_we = 1'b0; cpu_addr = 21'h000010; cpu_req = 1'b1;
    while (pulses < 3 && g < 300) begin
      @(negedge sys_clk);
      g++;
      if (cpu_ready) begin
        pulses++;
        chk("b2b_rdata", cpu_rdata, 32'hABCD1234);
        if (pulses == 3) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    repeat (6) @(negedge sys_clk);
    chk("b2b_pulses", 64'(ready_cnt - r0), 3);
    chk("b2b_xfers", 64'(xlog.size() - s0), 6);
    for (int i = 0; i < 6 && s0 + i < xlog.size(); i++)
      chk("b2b_addr", xlog[s0+i].addr, {21'h000010, i[0]});

    // reset in the high half of a read abandons it
    lat = 6;
    wait_idle();
    s0 = xlog.size(); r0 = ready_cnt; g = 0;
    cpu_we = 1'b0; cpu_addr = 21'h000010; cpu_req = 1'b1;
    @(posedge sys_clk);
    #1 cpu_req = 1'b0;
    @(negedge sys_clk);
    while (!(avl_READen && avl_addr[0]) && g < 100) begin
      @(negedge sys_clk);
      g++;
    end
    chk("rst_reached_hi", avl_READen && avl_addr[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready_busy", {cpu_ready, cpu_busy}, 0);
    chk("arst_rdata", cpu_rdata, 0);
    chk("arst_en", {avl_WRITEen, avl_READen}, 0);
    chk("arst_bus", {avl_addr, avl_byte_en, avl_WRDATA}, 0);
    @(negedge sys_clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("arst_no_ready", 64'(ready_cnt - r0), 0);
    chk("arst_xfers", 64'(xlog.size() - s0), 1);
    run_txn(1'b0, 21'h000010, 32'h0, 4'h0, 3, r_nx, r_first, r_rd);
    chk("post_rst_read", r_rd, 32'hABCD1234);

    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom % 2), 21'h000100 + 21'($urandom % 8), $urandom, 4'($urandom % 16),
              1 + int'($urandom % 4), r_nx, r_first, r_rd);

    chk("never_both_en", 64'(both_err), 0);
    chk("no_dup_xfer", 64'(dup_err), 0);
    chk("bus_stable", 64'(unstable_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sdram_word_bridge.md
SDRAM_WORD_BRIDGE -- requirements
Module: sdram_word_bridge

Interface
REQ-001: Clocking SHALL be one clock; reset is asynchronous and active-high (ports sys_clk, rst).
REQ-002: sys_clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  async active-high reset.
REQ-004: cpu_req  input  1  request strobe; sampled only in IDLE.
REQ-005: cpu_we  input  1  1 = write, 0 = read.
REQ-006: cpu_addr  input  21  32-bit word address.
REQ-007: cpu_wdata  input  32  write data.
REQ-008: cpu_be  input  4  byte enables; bit n covers cpu_wdata[8n+7:8n].
REQ-009: cpu_rdata  output  32  read data; valid while cpu_ready=1, held until the next read completes.
REQ-010: cpu_ready  output  1  one-cycle completion pulse.
REQ-011: cpu_busy  output  1  high whenever state is not IDLE.
REQ-012: avl_addr  output  22  halfword address {BA,ROW,COL} to the SDRAM controller.
REQ-013: avl_byte_en  output  2  halfword byte enables.
REQ-014: avl_WRITEen / avl_READen  output  1 each  transfer requests.
REQ-015: avl_WRDATA  output  16  halfword write data.
REQ-016: avl_RDDATA  input  16  halfword read data; valid only in the cycle avl_req_wait=0.
REQ-017: avl_req_wait  input  1  controller busy; a 0 for one cycle marks completion of the current transfer.

Function
REQ-018: The FSM SHALL have states IDLE, LO, HI and DONE.
REQ-019: On cpu_req=1 in IDLE, the bridge SHALL latch cpu_we, cpu_addr, cpu_wdata and cpu_be. Next state is LO, except a write with cpu_be[1:0]=0, which goes to HI.
REQ-020: A write with cpu_be=4'b0000 SHALL go directly IDLE->DONE with no Avalon activity.
REQ-021: LO SHALL drive avl_addr={addr,1'b0}, avl_WRDATA=wdata[15:0] and avl_byte_en=be[1:0] (writes) or 2'b11 (reads).
REQ-022: HI SHALL drive avl_addr={addr,1'b1}, avl_WRDATA=wdata[31:16] and avl_byte_en=be[3:2] (writes) or 2'b11 (reads).
REQ-023: All avl_* outputs SHALL be registered and held stable for the entire LO/HI state.
REQ-024: avl_WRITEen=latched we and avl_READen=~we in LO/HI; both SHALL be 0 in IDLE and DONE; both SHALL never be 1 together.
REQ-025: LO exit on avl_req_wait=0: capture avl_RDDATA into rdata[15:0] if read. Next state is HI, except a write with be[3:2]=0, which goes to DONE.
REQ-026: HI exit on avl_req_wait=0: capture avl_RDDATA into rdata[31:16] if read, then go to DONE.
REQ-027: Request deassertion SHALL take effect on the completion edge, so the controller sees en=0 (or the next halfword) in its following idle cycle; no duplicate transfer is issued.
REQ-028: DONE SHALL assert cpu_ready for exactly one cycle and return to IDLE. cpu_rdata SHALL update only for reads.
REQ-029: Latency SHALL be: avl_*en rises 1 cycle after cpu_req is accepted; cpu_ready rises 1 cycle after the last halfword completion.
REQ-030: cpu_req while busy SHALL be ignored and not queued. A request held high through DONE SHALL be re-accepted in the following IDLE cycle.
REQ-031: avl_req_wait=0 in IDLE or DONE SHALL be ignored.

Reset
REQ-032: rst=1 SHALL immediately force state IDLE and set cpu_ready=0, cpu_busy=0, cpu_rdata=0, avl_WRITEen=0, avl_READen=0, avl_addr=0, avl_byte_en=0 and avl_WRDATA=0.
REQ-033: Reset during LO/HI SHALL abandon the transaction; no cpu_ready pulse follows.

Verification
REQ-034: Read, addr=21'h00010, controller model returns 16'h1234 then 16'hABCD (wait low 6 cycles after en) -> avl_addr 22'h000020 then 22'h000021, avl_READen=1; cpu_rdata=32'hABCD1234 with one cpu_ready pulse.
REQ-035: Write, addr=21'h1FFFFF, data=32'hDEADBEEF, be=4'hF -> two writes: 22'h3FFFFE/16'hBEEF and 22'h3FFFFF/16'hDEAD, avl_byte_en=2'b11; one cpu_ready pulse.
REQ-036: Write be=4'b1100 -> single write at the odd halfword, byte_en=2'b11. Write be=4'b0010 -> single write at the even halfword, byte_en=2'b10. Write be=0 -> no avl activity; cpu_ready 1 cycle after accept.
REQ-037: cpu_req held high for 3 back-to-back reads -> exactly 6 Avalon transfers and 3 cpu_ready pulses; en never high in the cycle after any completion unless a new halfword is due.
REQ-038: rst pulsed while in HI of a read -> all outputs 0 asynchronously; no cpu_ready; the next read completes normally.
REQ-039: avl_req_wait glitched to 0 while IDLE -> no state change, no cpu_ready.
